// File: rtl/alu_issue_stage.sv
// Issue/execute/writeback stage around an external combinational ALU, one instruction per 3 cycles.
// Optional carry chain: define ALU_ISSUE_CARRY_CHAIN_EN.
module alu_issue_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [2:0]  op_code,
  output logic [31:0] carry_in,
  input  logic [31:0] alu_output,
  input  logic [31:0] alu_carry_out,
  output logic        result_valid,
  output logic [31:0] result,
  output logic [3:0]  result_dst,
  input  logic [3:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StWrite} state_e;

  state_e      state_q;
  logic [31:0] regs_q [16];
  logic [3:0]  dst_q;
  logic [31:0] result_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [2:0]  op_q;
  logic        ready_q;
  logic        valid_q;
  logic        unused_bits;

`ifdef ALU_ISSUE_CARRY_CHAIN_EN
  logic        carry_flag_q;
  logic [31:0] cin_q;
  assign unused_bits = ^alu_carry_out[31:1];
`else
  assign unused_bits = ^{alu_carry_out, instr[15]};
`endif

  // Operands are captured on acceptance; the previous write has already landed by then.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      for (int i = 0; i < 16; i++) begin
        regs_q[i] <= '0;
      end
      dst_q    <= '0;
      result_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
      carry_flag_q <= 1'b0;
      cin_q        <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (instr_valid) begin
            dst_q   <= instr[6:3];
            a_q     <= regs_q[instr[10:7]];
            b_q     <= regs_q[instr[14:11]];
            op_q    <= instr[2:0];
            ready_q <= 1'b0;
            state_q <= StIssue;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
            cin_q   <= instr[15] ? {31'b0, carry_flag_q} : '0;
`endif
          end
        end
        StIssue: begin
          result_q <= alu_output;
          a_q      <= '0;
          b_q      <= '0;
          op_q     <= '0;
          valid_q  <= 1'b1;
          state_q  <= StWrite;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
          if (op_q == 3'b000) begin
            carry_flag_q <= alu_carry_out[0];
          end
          cin_q <= '0;
`endif
        end
        StWrite: begin
          // R0 is never written so it always reads zero.
          if (dst_q != 4'd0) begin
            regs_q[dst_q] <= result_q;
          end
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign instr_ready  = ready_q;
  assign a            = a_q;
  assign b            = b_q;
  assign op_code      = op_q;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
  assign carry_in     = cin_q;
`else
  assign carry_in     = '0;
`endif
  assign result_valid = valid_q;
  assign result       = result_q;
  assign result_dst   = dst_q;
  assign dbg_data     = (dbg_addr == 4'd0) ? '0 : regs_q[dbg_addr];

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU attached to its operand outputs.
module tb_alu_issue_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  op_code;
  logic [31:0] carry_in;
  logic [31:0] alu_output;
  logic [31:0] alu_carry_out;
  logic        result_valid;
  logic [31:0] result;
  logic [3:0]  result_dst;
  logic [3:0]  dbg_addr = '0;
  logic [31:0] dbg_data;

  alu_issue_stage dut (
    .clock        (clock),
    .reset        (reset),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .a            (a),
    .b            (b),
    .op_code      (op_code),
    .carry_in     (carry_in),
    .alu_output   (alu_output),
    .alu_carry_out(alu_carry_out),
    .result_valid (result_valid),
    .result       (result),
    .result_dst   (result_dst),
    .dbg_addr     (dbg_addr),
    .dbg_data     (dbg_data)
  );

  always #5 clock = ~clock;

  // Behavioural ALU
  logic [32:0] alu_sum;
  always_comb begin
    alu_sum       = {1'b0, a} + {1'b0, b} + {1'b0, carry_in};
    alu_output    = '0;
    alu_carry_out = '0;
    case (op_code)
      3'b000: begin
        alu_output    = alu_sum[31:0];
        alu_carry_out = {31'b0, alu_sum[32]};
      end
      3'b001: alu_output = a & b;
      3'b010: alu_output = a * b;
      3'b011: alu_output = ~a;
      3'b100: alu_output = a - b;
      3'b101: alu_output = a | b;
      3'b110: alu_output = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      default: alu_output = a ^ b;
    endcase
  end

  typedef struct {
    logic [15:0] instr;
    logic [31:0] res;
  } vec_t;

  localparam int NumVec = 11;
  vec_t        vecs [NumVec];
  logic [31:0] mregs [16];
  logic        mflag;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && instr_ready !== 1'b1; i++) step();
    chk("ready_wait", {31'b0, instr_ready}, 32'd1);
  endtask

  task automatic accept(input logic [15:0] ins);
    wait_ready();
    instr       = ins;
    instr_valid = 1'b1;
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  sa, sb, d;
    logic [2:0]  op;
    logic [31:0] exp_cin;
    logic [32:0] s;
    logic [15:0] bb [3];
    int          idx;
    int          rv_cnt;

    vecs[0]  = '{16'h000B, 32'hFFFF_FFFF};  // NOT R0 -> R1
    vecs[1]  = '{16'h0890, 32'hFFFF_FFFE};  // ADD R1+R1 -> R2
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    vecs[2]  = '{16'h8018, 32'h0000_0001};  // ADD R0+R0+C -> R3
`else
    vecs[2]  = '{16'h8018, 32'h0000_0000};
`endif
    vecs[3]  = '{16'h0003, 32'hFFFF_FFFF};  // NOT R0 -> R0
    vecs[4]  = '{16'h10A7, 32'h0000_0001};  // XOR R1^R2 -> R4
    vecs[5]  = '{16'h212C, 32'hFFFF_FFFD};  // SUB R2-R4 -> R5
    vecs[6]  = '{16'h12B1, 32'hFFFF_FFFC};  // AND R5&R2 -> R6
    vecs[7]  = '{16'h1A3D, 32'h0000_0001};  // OR R4|R3 -> R7
    vecs[8]  = '{16'h2BC2, 32'hFFFF_FFFD};  // MUL R7*R5 -> R8
    vecs[9]  = '{16'h234E, 32'hFFFF_FFFC};  // DIV R6/R4 -> R9
    vecs[10] = '{16'h2250, 32'h0000_0002};  // ADD R4+R4 -> R10
    for (int i = 0; i < 16; i++) mregs[i] = '0;
    mflag = 1'b0;

    step();
    step();
    reset = 1'b0;
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_rvalid", {31'b0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_dst", {28'b0, result_dst}, 32'd0);
    chk("rst_a", a, 32'd0);
    chk("rst_b", b, 32'd0);
    chk("rst_op", {29'b0, op_code}, 32'd0);
    chk("rst_cin", carry_in, 32'd0);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      chk("rst_reg", dbg_data, 32'd0);
    end

    for (int i = 0; i < NumVec; i++) begin
      sa = vecs[i].instr[10:7];
      sb = vecs[i].instr[14:11];
      d  = vecs[i].instr[6:3];
      op = vecs[i].instr[2:0];
      exp_cin = '0;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
      exp_cin = vecs[i].instr[15] ? {31'b0, mflag} : '0;
`endif
      accept(vecs[i].instr);
      chk("iss_ready", {31'b0, instr_ready}, 32'd0);
      chk("iss_rvalid", {31'b0, result_valid}, 32'd0);
      chk("iss_a", a, mregs[sa]);
      chk("iss_b", b, mregs[sb]);
      chk("iss_op", {29'b0, op_code}, {29'b0, op});
      chk("iss_cin", carry_in, exp_cin);
      step();
      chk("wr_rvalid", {31'b0, result_valid}, 32'd1);
      chk("wr_result", result, vecs[i].res);
      chk("wr_dst", {28'b0, result_dst}, {28'b0, d});
      chk("wr_ready", {31'b0, instr_ready}, 32'd0);
      chk("wr_a", a, 32'd0);
      chk("wr_b", b, 32'd0);
      chk("wr_op", {29'b0, op_code}, 32'd0);
      chk("wr_cin", carry_in, 32'd0);
      if (op == 3'b000) begin
        s = {1'b0, mregs[sa]} + {1'b0, mregs[sb]} + {1'b0, exp_cin};
        mflag = s[32];
      end
      step();
      chk("idle_rvalid", {31'b0, result_valid}, 32'd0);
      chk("idle_ready", {31'b0, instr_ready}, 32'd1);
      if (d != 4'd0) mregs[d] = vecs[i].res;
      dbg_addr = d;
      #1;
      chk("dbg_dst", dbg_data, mregs[d]);
    end

    // Back-to-back with instr_valid held high
    bb[0] = 16'h005B;
    bb[1] = 16'h0063;
    bb[2] = 16'h006B;
    idx = 0;
    rv_cnt = 0;
    instr = bb[0];
    instr_valid = 1'b1;
    for (int c = 0; c < 9; c++) begin
      chk("b2b_ready", {31'b0, instr_ready}, (c % 3 == 0) ? 32'd1 : 32'd0);
      chk("b2b_rvalid", {31'b0, result_valid}, (c % 3 == 2) ? 32'd1 : 32'd0);
      if (result_valid) begin
        rv_cnt++;
        chk("b2b_dst", {28'b0, result_dst}, 32'(11 + c / 3));
      end
      step();
      if (c % 3 == 0) begin
        idx++;
        if (idx < 3) instr = bb[idx];
        else instr_valid = 1'b0;
      end
    end
    instr_valid = 1'b0;
    chk("b2b_count", 32'(rv_cnt), 32'd3);
    for (int r = 11; r < 14; r++) begin
      dbg_addr = 4'(r);
      #1;
      chk("b2b_reg", dbg_data, 32'hFFFF_FFFF);
    end

    // Reset during ISSUE abandons the instruction
    accept(16'h0023);
    chk("rissue_ready", {31'b0, instr_ready}, 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rissue_idle", {31'b0, instr_ready}, 32'd1);
    chk("rissue_rv0", {31'b0, result_valid}, 32'd0);
    step();
    chk("rissue_rv1", {31'b0, result_valid}, 32'd0);
    step();
    chk("rissue_rv2", {31'b0, result_valid}, 32'd0);
    dbg_addr = 4'd4;
    #1;
    chk("rissue_r4", dbg_data, 32'd0);
    dbg_addr = 4'd1;
    #1;
    chk("rissue_r1clr", dbg_data, 32'd0);

    // Reset during WRITE suppresses the register write
    accept(16'h007B);
    step();
    chk("rwrite_rv", {31'b0, result_valid}, 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rwrite_rv0", {31'b0, result_valid}, 32'd0);
    chk("rwrite_result", result, 32'd0);
    chk("rwrite_dst", {28'b0, result_dst}, 32'd0);
    chk("rwrite_ready", {31'b0, instr_ready}, 32'd1);
    dbg_addr = 4'd15;
    #1;
    chk("rwrite_r15", dbg_data, 32'd0);

    // Reset wins over a simultaneous instr_valid
    reset = 1'b1;
    instr = 16'h007B;
    instr_valid = 1'b1;
    step();
    reset = 1'b0;
    instr_valid = 1'b0;
    chk("rprio_ready", {31'b0, instr_ready}, 32'd1);
    step();
    chk("rprio_ready2", {31'b0, instr_ready}, 32'd1);
    chk("rprio_rv", {31'b0, result_valid}, 32'd0);
    step();
    chk("rprio_rv2", {31'b0, result_valid}, 32'd0);
    chk("rprio_r15", dbg_data, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
